sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares one sdram_interface command/response port between NUM_PORTS requesters (e.g. video fetch, CPU, DMA).
- Round-robin command arbitration with a valid/ack handshake.
- Records the issuing port of every read in a tag FIFO, so returned burst beats (BURST_LENGTH per read, in order) are routed back to the correct requester.
- Sits directly between the client blocks and the SDRAM controller's address/data_in/read/write/ready/valid/data_out port.

Parameters:
- NUM_PORTS, 2, number of requesters (2..4)
- ADDR_W, 25, command address width ({bank[24:23], row[22:10], col[9:0]})
- DATA_W, 16, data width
- BURST_LENGTH, 4, read beats returned per read command; must equal the controller's BURST_LENGTH (1, 2, 4 or 8)
- TAG_DEPTH, 16, outstanding-read capacity (power of 2)

Ports:
- clk  in  1  clock; the single clock for the block
- reset  in  1  synchronous, active-high reset
- p_read  in  NUM_PORTS  per-port read request, held until acked
- p_write  in  NUM_PORTS  per-port write request, held until acked
- p_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
- p_wdata  in  NUM_PORTS*DATA_W  per-port write data
- p_ack  out  NUM_PORTS  one-hot; command of port i taken this cycle
- p_rvalid  out  NUM_PORTS  one-hot; read beat for port i on p_rdata
- p_rdata  out  DATA_W  read data, broadcast to all ports
- m_read  out  1  to controller read
- m_write  out  1  to controller write
- m_addr  out  ADDR_W  to controller address
- m_wdata  out  DATA_W  to controller data_in
- m_ready  in  1  controller ready
- m_valid  in  1  controller valid (one pulse per beat)
- m_rdata  in  DATA_W  controller data_out
- err_illegal  out  1  sticky; a port drove read and write together
- err_orphan  out  1  sticky; m_valid arrived with the tag FIFO empty

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - rr_ptr=0, tag FIFO empty, beat_cnt=0, err_illegal=0, err_orphan=0.
  - All outputs are 0 during and after reset until a request arrives.
- Eligibility: port i is eligible when p_read[i]^p_write[i] is 1.
  - An eligible read additionally requires tag FIFO not full.
  - p_read[i]&p_write[i]: port not eligible, err_illegal set (sticky until reset).
- Arbitration (combinational, same cycle):
  - If m_ready=1, select the first eligible port scanning rr_ptr, rr_ptr+1, ... mod NUM_PORTS.
  - Winner w: p_ack[w]=1; m_read/m_write/m_addr/m_wdata = port w's inputs.
  - Zero latency from request to issue. Exactly one command per cycle max.
  - m_read and m_write are never both 1, and are 0 whenever m_ready=0.
  - m_addr/m_wdata are 0 when no command is issued.
- rr_ptr update: on issue, rr_ptr <= (w+1) mod NUM_PORTS; otherwise unchanged.
  - Fairness: a continuously requesting port waits at most NUM_PORTS-1 issues.
- Requester rule: hold read/write/addr/wdata stable until p_ack; deassert or present a new command in the cycle after ack.
- Tag FIFO: push index w when a read is issued.
- Response routing:
  - On m_valid with FIFO non-empty: p_rvalid[head]=1 combinationally, p_rdata=m_rdata (always passthrough).
  - beat_cnt increments per beat. On beat BURST_LENGTH-1: pop head, beat_cnt<=0.
  - Push and pop in the same cycle are both performed; occupancy unchanged.
  - Full: reads are not eligible, writes still proceed.
  - m_valid with FIFO empty: p_rvalid=0, err_orphan set, beat_cnt unchanged.
- Writes: no response tracking; a write is complete from the requester's view at p_ack.
- Reset mid-operation: outstanding tags are discarded. The controller shares the reset, so no stale beats are expected; any that arrive raise err_orphan.
- Widths: rr_ptr and tag are $clog2(NUM_PORTS) bits (min 1). Occupancy count is $clog2(TAG_DEPTH)+1 bits. beat_cnt is 3 bits.

Decomposition:
- Shared package sdram_pkg holds:
  - SDRAM_ADDR_W=25, SDRAM_DATA_W=16
  - bank/row/column field offsets
  - SDRAM_BURST_LENGTH, for both the controller and this arbiter
- Sub-module sdram_tag_fifo:
  - synchronous FIFO, width $clog2(NUM_PORTS), depth TAG_DEPTH
  - push/pop/full/empty/head; same-cycle push+pop allowed when full
- Arbiter top: round-robin select, beat counter, error flags.

Test Plan:
- Port 0 write addr 0x0000010 data 0xBEEF, m_ready=1 -> same cycle: p_ack=01, m_write=1, m_addr=0x0000010, m_wdata=0xBEEF; rr_ptr=1.
- Ports 0 and 1 hold reads continuously, m_ready=1 -> acks alternate 01,10,01,10. Controller model returns 4 beats per read in order -> p_rvalid pattern 01x4, 10x4, 01x4.
- m_ready=0 for 5 cycles with both ports requesting -> no ack, m_read=m_write=0, rr_ptr unchanged. m_ready rises -> port at rr_ptr acked first.
- TAG_DEPTH=16: issue 16 reads with no m_valid -> 17th read not acked, a concurrent write on port 1 is acked. After 4 beats return -> read acked the next cycle.
- Port 1 p_read=p_write=1 -> never acked, err_illegal=1 sticky. An m_valid with no outstanding read -> err_orphan=1, all p_rvalid=0.
- Reset asserted after beat 2 of a read -> next cycle all outputs 0, FIFO empty. A new read then issues and routes all 4 beats to its own port.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM geometry and burst constants for the controller and its clients.
package sdram_pkg;

    localparam int SDRAM_ADDR_W       = 25;
    localparam int SDRAM_DATA_W       = 16;
    localparam int SDRAM_COL_LSB      = 0;
    localparam int SDRAM_COL_W        = 10;
    localparam int SDRAM_ROW_LSB      = 10;
    localparam int SDRAM_ROW_W        = 13;
    localparam int SDRAM_BANK_LSB     = 23;
    localparam int SDRAM_BANK_W       = 2;
    localparam int SDRAM_BURST_LENGTH = 4;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_READ,
        CMD_WRITE
    } cmd_e;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Small synchronous FIFO of port indices; push and pop may share a cycle,
// including when full.
module sdram_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    always_comb begin
        do_push = push_i && (!full_o || pop_i);
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of one SDRAM controller port; read beats are routed
// back to the issuing requester through a tag FIFO.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_W       = SDRAM_ADDR_W,
    parameter int DATA_W       = SDRAM_DATA_W,
    parameter int BURST_LENGTH = SDRAM_BURST_LENGTH,
    parameter int TAG_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        p_read,
    input  logic [NUM_PORTS-1:0]        p_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
    output logic [NUM_PORTS-1:0]        p_ack,
    output logic [NUM_PORTS-1:0]        p_rvalid,
    output logic [DATA_W-1:0]           p_rdata,
    output logic                        m_read,
    output logic                        m_write,
    output logic [ADDR_W-1:0]           m_addr,
    output logic [DATA_W-1:0]           m_wdata,
    input  logic                        m_ready,
    input  logic                        m_valid,
    input  logic [DATA_W-1:0]           m_rdata,
    output logic                        err_illegal,
    output logic                        err_orphan
);

    localparam int PW = ptr_w(NUM_PORTS);

    logic [PW-1:0]        rr_q, rr_d;
    logic [2:0]           beat_q, beat_d;
    logic                 ill_q, ill_d;
    logic                 orph_q, orph_d;
    logic [NUM_PORTS-1:0] elig;
    logic                 issue;
    logic [PW-1:0]        win;
    cmd_e                 cmd;
    logic                 fifo_full, fifo_empty;
    logic [PW-1:0]        head;
    logic                 beat, pop;

    sdram_tag_fifo #(
        .W     (PW),
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .clk         (clk),
        .reset       (reset),
        .push_i      (cmd == CMD_READ),
        .push_data_i (win),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    // Descending scan so the port closest to rr_q is the last to claim win.
    always_comb begin
        elig  = (p_read ^ p_write) & (p_write | {NUM_PORTS{!fifo_full}});
        issue = 1'b0;
        win   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (elig[(int'(rr_q) + k) % NUM_PORTS]) begin
                issue = 1'b1;
                win   = PW'((int'(rr_q) + k) % NUM_PORTS);
            end
        end
        issue = issue && m_ready && !reset;
    end

    always_comb begin
        p_ack   = '0;
        m_read  = 1'b0;
        m_write = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        cmd     = CMD_NONE;
        rr_d    = rr_q;
        if (issue) begin
            p_ack[win] = 1'b1;
            m_read     = p_read[win];
            m_write    = p_write[win];
            m_addr     = p_addr[win*ADDR_W +: ADDR_W];
            m_wdata    = p_wdata[win*DATA_W +: DATA_W];
            cmd        = p_read[win] ? CMD_READ : CMD_WRITE;
            rr_d       = PW'((int'(win) + 1) % NUM_PORTS);
        end
    end

    always_comb begin
        beat     = m_valid && !fifo_empty && !reset;
        pop      = beat && (beat_q == 3'(BURST_LENGTH - 1));
        p_rvalid = '0;
        if (beat) p_rvalid[head] = 1'b1;
        p_rdata  = m_rdata;
        beat_d   = beat ? (pop ? 3'd0 : beat_q + 3'd1) : beat_q;
        ill_d    = ill_q | (|(p_read & p_write));
        orph_d   = orph_q | (m_valid & fifo_empty);
    end

    assign err_illegal = ill_q;
    assign err_orphan  = orph_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q   <= '0;
            beat_q <= '0;
            ill_q  <= 1'b0;
            orph_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            beat_q <= beat_d;
            ill_q  <= ill_d;
            orph_q <= orph_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based model of arbitration and burst routing.
module tb_sdram_port_arbiter;
    import sdram_pkg::*;

    localparam int N  = 2;
    localparam int AW = SDRAM_ADDR_W;
    localparam int DW = SDRAM_DATA_W;
    localparam int BL = SDRAM_BURST_LENGTH;
    localparam int TD = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  p_read, p_write, p_ack, p_rvalid;
    logic [N*AW-1:0] p_addr;
    logic [N*DW-1:0] p_wdata;
    logic [DW-1:0] p_rdata, m_wdata, m_rdata;
    logic          m_read, m_write, m_ready, m_valid;
    logic [AW-1:0] m_addr;
    logic          err_illegal, err_orphan;

    sdram_port_arbiter #(
        .NUM_PORTS    (N),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .BURST_LENGTH (BL),
        .TAG_DEPTH    (TD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p_read      (p_read),
        .p_write     (p_write),
        .p_addr      (p_addr),
        .p_wdata     (p_wdata),
        .p_ack       (p_ack),
        .p_rvalid    (p_rvalid),
        .p_rdata     (p_rdata),
        .m_read      (m_read),
        .m_write     (m_write),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .m_rdata     (m_rdata),
        .err_illegal (err_illegal),
        .err_orphan  (err_orphan)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state: next port to favour, owners of outstanding reads
    int rr_m = 0;
    int tagq[$];
    int beats_m = 0;
    bit ill_m = 1'b0;
    bit orph_m = 1'b0;
    int last_win = -1;
    bit pend[N];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] mk(input int b, input int r, input int c);
        logic [AW-1:0] a;
        a = (AW'(b & ((1 << SDRAM_BANK_W) - 1)) << SDRAM_BANK_LSB)
          | (AW'(r & ((1 << SDRAM_ROW_W) - 1)) << SDRAM_ROW_LSB)
          | (AW'(c & ((1 << SDRAM_COL_W) - 1)) << SDRAM_COL_LSB);
        return a;
    endfunction

    task automatic model_cycle();
        logic [N-1:0]  e_ack, e_rv;
        logic          e_mr, e_mw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        int            w;
        e_ack = '0; e_rv = '0; e_mr = 0; e_mw = 0;
        e_addr = '0; e_wd = '0; w = -1;
        if (!reset && m_ready) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (rr_m + k) % N;
                if (w < 0 && (p_read[i] != p_write[i])
                    && (p_write[i] || tagq.size() < TD)) w = i;
            end
        end
        if (w >= 0) begin
            e_ack[w] = 1'b1;
            e_mr     = p_read[w];
            e_mw     = p_write[w];
            e_addr   = p_addr[w*AW +: AW];
            e_wd     = p_wdata[w*DW +: DW];
        end
        if (!reset && m_valid && tagq.size() > 0) e_rv[tagq[0]] = 1'b1;
        chk("p_ack", p_ack, e_ack);
        chk("m_read", m_read, e_mr);
        chk("m_write", m_write, e_mw);
        chk("m_addr", m_addr, e_addr);
        chk("m_wdata", m_wdata, e_wd);
        chk("p_rvalid", p_rvalid, e_rv);
        chk("p_rdata", p_rdata, m_rdata);
        chk("err_illegal", err_illegal, ill_m);
        chk("err_orphan", err_orphan, orph_m);
        last_win = w;
        if (reset) begin
            rr_m = 0; tagq.delete(); beats_m = 0; ill_m = 0; orph_m = 0;
        end else begin
            if ((p_read & p_write) != 0) ill_m = 1'b1;
            if (m_valid && tagq.size() == 0) orph_m = 1'b1;
            if (e_rv != 0) begin
                beats_m++;
                if (beats_m == BL) begin
                    void'(tagq.pop_front());
                    beats_m = 0;
                end
            end
            if (w >= 0) begin
                if (e_mr) tagq.push_back(w);
                rr_m = (w + 1) % N;
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic commit();
        model_cycle();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        commit();
    endtask

    task automatic clr();
        p_read = '0; p_write = '0; p_addr = '0; p_wdata = '0;
        m_ready = 0; m_valid = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        @(negedge clk);
        @(negedge clk);

        // single write, zero-latency issue
        do_reset();
        m_ready = 1;
        p_write = 2'b01;
        p_addr[0 +: AW] = 25'h0000010;
        p_wdata[0 +: DW] = 16'hBEEF;
        settle();
        chk("w_ack", p_ack, 2'b01);
        chk("w_mwrite", m_write, 1'b1);
        chk("w_maddr", m_addr, 25'h0000010);
        chk("w_mwdata", m_wdata, 16'hBEEF);
        commit();
        p_write = 2'b11;
        p_addr[AW +: AW] = mk(1, 77, 5);
        p_wdata[DW +: DW] = 16'h1234;
        settle();
        chk("rr_after_w", p_ack, 2'b10);
        commit();
        p_write = 2'b01;
        settle();
        chk("w_second", p_ack, 2'b01);
        commit();

        // alternating reads and in-order burst routing
        do_reset();
        m_ready = 1;
        p_read = 2'b11;
        p_addr = {mk(2, 100, 8), mk(3, 200, 16)};
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rd_alt", p_ack, (k % 2) ? 2'b10 : 2'b01);
            chk("rd_mread", m_read, 1'b1);
            commit();
        end
        p_read = '0;
        m_valid = 1;
        for (int b = 0; b < 4 * BL; b++) begin
            m_rdata = DW'($urandom);
            settle();
            chk("rv_pat", p_rvalid, ((b / BL) % 2) ? 2'b10 : 2'b01);
            commit();
        end
        m_valid = 0;

        // controller stall holds the pointer
        p_write = 2'b11;
        m_ready = 0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("stall_ack", p_ack, 2'b00);
            chk("stall_cmd", {m_read, m_write}, 2'b00);
            commit();
        end
        m_ready = 1;
        settle();
        chk("stall_rel", p_ack, 2'b01);
        commit();
        p_write = 2'b10;
        settle();
        chk("stall_next", p_ack, 2'b10);
        commit();

        // tag FIFO full blocks reads but not writes
        do_reset();
        m_ready = 1;
        p_read = 2'b01;
        for (int k = 0; k < TD; k++) begin
            settle();
            chk("fill_ack", p_ack, 2'b01);
            commit();
        end
        p_write = 2'b10;
        settle();
        chk("full_wr", p_ack, 2'b10);
        chk("full_mwrite", m_write, 1'b1);
        commit();
        p_write = '0;
        settle();
        chk("full_rd", p_ack, 2'b00);
        commit();
        m_valid = 1;
        for (int b = 0; b < BL; b++) begin
            settle();
            chk("full_drain", p_ack, 2'b00);
            chk("full_rv", p_rvalid, 2'b01);
            commit();
        end
        m_valid = 0;
        settle();
        chk("unfull_rd", p_ack, 2'b01);
        commit();
        p_read = '0;

        // illegal request and orphan beat
        do_reset();
        m_ready = 1;
        p_read = 2'b10;
        p_write = 2'b10;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("ill_ack", p_ack, 2'b00);
            commit();
        end
        p_read = '0;
        p_write = '0;
        settle();
        chk("ill_sticky", err_illegal, 1'b1);
        commit();
        m_valid = 1;
        settle();
        chk("orph_rv", p_rvalid, 2'b00);
        commit();
        m_valid = 0;
        settle();
        chk("orph_flag", err_orphan, 1'b1);
        chk("ill_still", err_illegal, 1'b1);
        commit();

        // reset in the middle of a burst discards the outstanding tag
        do_reset();
        m_ready = 1;
        p_read = 2'b01;
        cyc();
        p_read = '0;
        m_valid = 1;
        cyc();
        cyc();
        m_valid = 0;
        reset = 1;
        cyc();
        reset = 0;
        settle();
        chk("mid_out", {p_ack, p_rvalid, m_read, m_write}, '0);
        chk("mid_bus", {m_addr, m_wdata}, '0);
        chk("mid_err", {err_illegal, err_orphan}, 2'b00);
        commit();
        p_read = 2'b10;
        settle();
        chk("mid_newrd", p_ack, 2'b10);
        commit();
        p_read = '0;
        m_valid = 1;
        for (int b = 0; b < BL; b++) begin
            m_rdata = DW'($urandom);
            settle();
            chk("mid_route", p_rvalid, 2'b10);
            commit();
        end
        m_valid = 0;

        // randomized traffic under the reference model
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_win == i) begin
                    pend[i] = 1'b0;
                    p_read[i] = 1'b0;
                    p_write[i] = 1'b0;
                end
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    bit rd;
                    rd = 1'($urandom);
                    p_read[i] = rd;
                    p_write[i] = !rd;
                    p_addr[i*AW +: AW] = mk($urandom, $urandom, $urandom);
                    p_wdata[i*DW +: DW] = DW'($urandom);
                    pend[i] = 1'b1;
                end
            end
            m_ready = ($urandom_range(0, 4) != 0);
            m_valid = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
            m_rdata = DW'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
